// File: rtl/round_robin_arbiter_6.sv
// ---------------------------------------------------------------------------
// RoundRobinArbiter6
//
// Purpose:
//   Shares one datapath resource among six requesters. A rotating priority
//   pointer picks the next grantee. The grant is held until one of these
//   happens: the grantee signals Done, the grantee withdraws its request, or
//   a hold limit expires. Every grant is followed by a one-cycle turnaround
//   (RELEASE) before the next grant is issued.
//
// Parameters:
//   RequestMask  per-requester polarity; bit i = 1 makes Req[i] active-low
//   MaxHold      maximum number of cycles a grant may stay asserted (2..255)
//
// Ports:
//   Clock    in   system clock; all state changes on its rising edge
//   Reset    in   synchronous, active-high reset
//   Req      in   [5:0] raw request lines (polarity set by RequestMask)
//   Done     in   current grantee has finished; only looked at in GRANT
//   Grant    out  [5:0] one-hot registered grant
//   GrantId  out  [2:0] binary index of the grantee, 0 when nothing granted
//   Busy     out  high while a grant is active
//   Timeout  out  one-cycle pulse when a grant is revoked by the hold limit
// ---------------------------------------------------------------------------
module round_robin_arbiter_6 #(
   parameter logic [5:0] RequestMask = 6'b000000,
   parameter int         MaxHold     = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [5:0] Req,
   input  logic       Done,
   output logic [5:0] Grant,
   output logic [2:0] GrantId,
   output logic       Busy,
   output logic       Timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // The hold counter starts at 0 on the first granted cycle, so the grant
   // is revoked on the edge where it reaches MaxHold-1.
   localparam logic [7:0] HoldLimit = 8'(MaxHold - 1);

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [7:0] r_holdCnt;
   logic [5:0] r_grant;
   logic [2:0] r_grantId;
   logic       r_busy;
   logic       r_timeout;

   logic [5:0] w_eReq;
   logic       w_anyReq;
   logic [2:0] w_winner;
   logic [3:0] w_idx;
   logic       w_found;
   logic [2:0] w_nextPtr;

   // Normalise request polarity so the arbitration logic only ever deals
   // with active-high requests.
   assign w_eReq   = Req ^ RequestMask;
   assign w_anyReq = |w_eReq;

   // Rotating-priority search: walk the six positions starting at the
   // pointer, wrapping 5 -> 0, and take the first active request.
   always_comb begin
      w_winner = 3'd0;
      w_found  = 1'b0;
      w_idx    = 4'd0;
      for (int k = 0; k < 6; k++) begin
         w_idx = {1'b0, r_ptr} + 4'(k);
         if (w_idx >= 4'd6) begin
            w_idx = w_idx - 4'd6;
         end
         if (!w_found && w_eReq[w_idx[2:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[2:0];
         end
      end
   end

   // After a grant, the requester just served becomes the lowest priority
   // by moving the pointer one past it.
   assign w_nextPtr = (r_grantId == 3'd5) ? 3'd0 : 3'(r_grantId + 3'd1);

   // Main controller: state, pointer, hold counter and all registered
   // outputs are updated together so the outputs never glitch. Timeout
   // defaults low each cycle and is only raised on a hold-limit revoke,
   // which yields the single-cycle pulse during RELEASE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_ptr     <= 3'd0;
         r_holdCnt <= 8'd0;
         r_grant   <= 6'b000000;
         r_grantId <= 3'd0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE, RELEASE: begin
               r_grant   <= 6'b000000;
               r_grantId <= 3'd0;
               r_busy    <= 1'b0;
               r_holdCnt <= 8'd0;
               if (w_anyReq) begin
                  r_state   <= GRANT;
                  r_grant   <= 6'b000001 << w_winner;
                  r_grantId <= w_winner;
                  r_busy    <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end

            GRANT: begin
               // Done takes precedence over the hold limit, so a completion
               // on the final allowed cycle is not reported as a timeout.
               if (Done || !w_eReq[r_grantId] || (r_holdCnt == HoldLimit)) begin
                  r_state   <= RELEASE;
                  r_ptr     <= w_nextPtr;
                  r_grant   <= 6'b000000;
                  r_grantId <= 3'd0;
                  r_busy    <= 1'b0;
                  r_holdCnt <= 8'd0;
                  r_timeout <= !Done && w_eReq[r_grantId];
               end else begin
                  r_holdCnt <= r_holdCnt + 8'd1;
               end
            end

            default: begin
               r_state   <= IDLE;
               r_grant   <= 6'b000000;
               r_grantId <= 3'd0;
               r_busy    <= 1'b0;
               r_holdCnt <= 8'd0;
            end
         endcase
      end
   end

   assign Grant   = r_grant;
   assign GrantId = r_grantId;
   assign Busy    = r_busy;
   assign Timeout = r_timeout;

endmodule

// File: tb/tb_round_robin_arbiter_6.sv
// ---------------------------------------------------------------------------
// tb_round_robin_arbiter_6
//
// Directed bench for the six-way round-robin arbiter. The arbiter is built
// with a short hold limit (4) and requester 0 active-low, so masking, the
// timeout path and the pointer behaviour can all be reached in a short run.
// Stimulus is written in terms of effective (active-high) requests and
// converted to raw pin levels by applyStimulus.
// ---------------------------------------------------------------------------
module tb_round_robin_arbiter_6;

   localparam logic [5:0] Mask = 6'b000001;
   localparam int         Hold = 4;

   logic       clock;
   logic       reset;
   logic [5:0] req;
   logic       done;
   logic [5:0] grant;
   logic [2:0] grantId;
   logic       busy;
   logic       timeout;

   int compared;
   int mismatched;

   round_robin_arbiter_6 #(
      .RequestMask(Mask),
      .MaxHold    (Hold)
   ) dut (
      .Clock  (clock),
      .Reset  (reset),
      .Req    (req),
      .Done   (done),
      .Grant  (grant),
      .GrantId(grantId),
      .Busy   (busy),
      .Timeout(timeout)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive effective requests; the raw pin level is the effective level
   // flipped on masked (active-low) requesters.
   task automatic applyStimulus(input logic [5:0] eReq, input logic doneIn);
      req  = eReq ^ Mask;
      done = doneIn;
   endtask

   // Advance one rising edge and settle past it before sampling.
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // Compare all four outputs against hand-computed values.
   task automatic checkOutput(input string tag, input logic [5:0] expGrant,
                              input logic [2:0] expId, input logic expBusy,
                              input logic expTimeout);
      compared++;
      assert (grant === expGrant) else begin
         mismatched++;
         $error("[TB] FAIL %s grant observed=%b expected=%b", tag, grant, expGrant);
      end
      compared++;
      assert (grantId === expId) else begin
         mismatched++;
         $error("[TB] FAIL %s grantId observed=%0d expected=%0d", tag, grantId, expId);
      end
      compared++;
      assert (busy === expBusy) else begin
         mismatched++;
         $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
      end
      compared++;
      assert (timeout === expTimeout) else begin
         mismatched++;
         $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, timeout, expTimeout);
      end
   endtask

   // Linear directed sequence; each step notes the arbiter state it targets.
   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      applyStimulus(6'b000000, 1'b0);

      // Reset held for two edges keeps every output at zero.
      cycle();
      checkOutput("reset1", 6'b000000, 3'd0, 1'b0, 1'b0);
      cycle();
      checkOutput("reset2", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Requests 1 and 3 from pointer 0: requester 1 wins, one-cycle latency.
      reset = 1'b0;
      applyStimulus(6'b001010, 1'b0);
      cycle();
      checkOutput("firstGrant", 6'b000010, 3'd1, 1'b1, 1'b0);

      // Done releases requester 1; turnaround cycle has no grant.
      applyStimulus(6'b001010, 1'b1);
      cycle();
      checkOutput("release1", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Pointer is now 2, so pending requester 3 wins.
      applyStimulus(6'b001000, 1'b0);
      cycle();
      checkOutput("grant3", 6'b001000, 3'd3, 1'b1, 1'b0);

      // Requests from 0 and 1 during the grant do not preempt.
      applyStimulus(6'b001011, 1'b0);
      cycle();
      checkOutput("noPreempt", 6'b001000, 3'd3, 1'b1, 1'b0);

      // Done on requester 3 moves the pointer to 4.
      applyStimulus(6'b001011, 1'b1);
      cycle();
      checkOutput("release3", 6'b000000, 3'd0, 1'b0, 1'b0);

      // From pointer 4, the search wraps past 5 and finds requester 0.
      applyStimulus(6'b001011, 1'b0);
      cycle();
      checkOutput("ptr4Wrap", 6'b000001, 3'd0, 1'b1, 1'b0);

      // Grantee 0 withdraws its request: release without timeout.
      applyStimulus(6'b001010, 1'b0);
      cycle();
      checkOutput("reqDrop", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Only requester 5 asks; pointer 1 search lands on 5.
      applyStimulus(6'b100000, 1'b0);
      cycle();
      checkOutput("grant5", 6'b100000, 3'd5, 1'b1, 1'b0);

      // Release 5 with requests 5 and 0 pending: pointer wraps to 0.
      applyStimulus(6'b100001, 1'b1);
      cycle();
      checkOutput("release5", 6'b000000, 3'd0, 1'b0, 1'b0);
      applyStimulus(6'b100001, 1'b0);
      cycle();
      checkOutput("wrapTo0", 6'b000001, 3'd0, 1'b1, 1'b0);

      // Release 0 and let requester 2 take the resource.
      applyStimulus(6'b000100, 1'b1);
      cycle();
      checkOutput("release0", 6'b000000, 3'd0, 1'b0, 1'b0);
      applyStimulus(6'b000100, 1'b0);
      cycle();
      checkOutput("hold2c1", 6'b000100, 3'd2, 1'b1, 1'b0);

      // Requester 2 holds without Done: grant visible for exactly 4 cycles.
      cycle();
      checkOutput("hold2c2", 6'b000100, 3'd2, 1'b1, 1'b0);
      cycle();
      checkOutput("hold2c3", 6'b000100, 3'd2, 1'b1, 1'b0);
      cycle();
      checkOutput("hold2c4", 6'b000100, 3'd2, 1'b1, 1'b0);
      cycle();
      checkOutput("timeout2", 6'b000000, 3'd0, 1'b0, 1'b1);

      // Pointer is 3 after the timeout, so 3 beats 2; Timeout pulse is gone.
      applyStimulus(6'b001100, 1'b0);
      cycle();
      checkOutput("afterTimeout", 6'b001000, 3'd3, 1'b1, 1'b0);

      // Requester 3 holds to the limit, but Done arrives on that same edge.
      cycle();
      checkOutput("hold3c2", 6'b001000, 3'd3, 1'b1, 1'b0);
      cycle();
      checkOutput("hold3c3", 6'b001000, 3'd3, 1'b1, 1'b0);
      cycle();
      checkOutput("hold3c4", 6'b001000, 3'd3, 1'b1, 1'b0);
      applyStimulus(6'b001000, 1'b1);
      cycle();
      checkOutput("doneWins", 6'b000000, 3'd0, 1'b0, 1'b0);

      // No requests after release: IDLE; Done while idle changes nothing.
      applyStimulus(6'b000000, 1'b1);
      cycle();
      checkOutput("idle", 6'b000000, 3'd0, 1'b0, 1'b0);
      cycle();
      checkOutput("doneInIdle", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Raw pins all low: requester 0 is active-low, so it is granted.
      req  = 6'b000000;
      done = 1'b0;
      cycle();
      checkOutput("maskGrant0", 6'b000001, 3'd0, 1'b1, 1'b0);

      // Release 0 with requests 4 and 0; pointer 1 picks requester 4.
      applyStimulus(6'b010001, 1'b1);
      cycle();
      checkOutput("releaseMask0", 6'b000000, 3'd0, 1'b0, 1'b0);
      applyStimulus(6'b010001, 1'b0);
      cycle();
      checkOutput("grant4", 6'b010000, 3'd4, 1'b1, 1'b0);

      // Reset in the middle of the grant drops it with no Timeout.
      reset = 1'b1;
      cycle();
      checkOutput("resetMidGrant", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Reset still asserted overrides Done and every request.
      applyStimulus(6'b111111, 1'b1);
      cycle();
      checkOutput("resetHeld", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Pointer back at 0 after reset: requester 0 beats requester 4.
      reset = 1'b0;
      applyStimulus(6'b010001, 1'b0);
      cycle();
      checkOutput("postReset", 6'b000001, 3'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter_6.md
ROUND_ROBIN_ARBITER_6 -- requirements
Module: round_robin_arbiter_6

Interface
REQ-001 Parameter RequestMask, default 6'b000000: per-requester inversion; bit i = 1 means Req[i] is active-low.
REQ-002 Parameter MaxHold, default 16: maximum cycles a grant may stay asserted; legal range 2..255.
REQ-003 Port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port Req  input  6  request lines from six requesters sharing one datapath resource.
REQ-006 Port Done  input  1  current grantee signals completion; sampled only in GRANT.
REQ-007 Port Grant  output  6  one-hot grant, registered.
REQ-008 Port GrantId  output  3  binary index of the current grantee, 3'd0 when no grant.
REQ-009 Port Busy  output  1  high while in GRANT.
REQ-010 Port Timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 Effective request: eReq[i] = Req[i] XOR RequestMask[i]; all arbitration uses eReq.
REQ-012 State machine: IDLE, GRANT, RELEASE; encoded in a registered state field.
REQ-013 Round-robin pointer Ptr (0..5): winner = first i with eReq[i]=1, searching Ptr, Ptr+1, ..., wrapping 5->0.
REQ-014 IDLE: Grant=0; if any eReq at an edge -> GRANT with winner latched; else stay IDLE.
REQ-015 Latency: eReq sampled at edge N produces Grant valid after edge N (one cycle).
REQ-016 GRANT: Grant, GrantId, Busy held constant; hold counter HoldCnt increments each cycle from 0.
REQ-017 GRANT exit on Done=1 -> RELEASE, Timeout stays 0.
REQ-018 GRANT exit when grantee eReq drops to 0 -> RELEASE, Timeout stays 0.
REQ-019 GRANT exit when HoldCnt = MaxHold-1 and no Done -> RELEASE, Timeout=1 for exactly the RELEASE cycle.
REQ-020 Done and hold limit on the same edge: Done wins, Timeout=0.
REQ-021 On every GRANT->RELEASE transition Ptr = (grantee+1) mod 6, wrapping 5->0.
REQ-022 RELEASE: Grant=0, Busy=0 for exactly one cycle (turnaround); arbitrates with updated Ptr; any eReq -> GRANT, else IDLE.
REQ-023 Grant is never asserted to two requesters and never asserted in IDLE or RELEASE.
REQ-024 Requests arriving during GRANT from other requesters are ignored until RELEASE; no preemption.
REQ-025 HoldCnt width 8 bits; cleared on entry to GRANT; never wraps (exit precedes overflow).
REQ-026 Done outside GRANT has no effect.

Reset
REQ-027 Reset=1 at an edge: state=IDLE, Ptr=0, HoldCnt=0, Grant=6'b0, GrantId=0, Busy=0, Timeout=0, overriding all other inputs.
REQ-028 Reset mid-GRANT: grant dropped after that edge with no Timeout pulse; first arbitration after reset favours Req[0].
REQ-029 Reset held multiple cycles: outputs stay at reset values throughout.

Verification
REQ-030 After reset, Req=6'b001010 one cycle -> next cycle Grant=6'b000010, GrantId=1, Busy=1.
REQ-031 Grantee 1, Done=1 -> one cycle Grant=0 (RELEASE), then Grant=6'b001000 (Req3 still pending), Ptr=2 then 4 on its release.
REQ-032 Grantee 5 released with Req=6'b100001 -> next grant to Req0 (pointer wrap), not Req5.
REQ-033 MaxHold=4, grantee 2 holds Req, no Done -> Grant high exactly 4 cycles, Timeout=1 for the following single cycle, Ptr=3.
REQ-034 Done and timeout on the same edge -> Timeout=0; RequestMask=6'b000001 with Req=6'b000000 -> Req0 granted.
REQ-035 Reset asserted during GRANT of requester 4 -> next cycle all outputs 0; with Req=6'b010001 afterwards, Req0 granted first.
